// File: rtl/ps2_keyboard_rx.sv
// PS/2 device-to-host receiver: synchronizes ps2_clk/ps2_data, deserializes
// 11-bit frames, validates start/odd-parity/stop and queues good scan codes.
module ps2_keyboard_rx #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned TIMEOUT    = 2000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       nextdata_n,
    output logic [7:0] data,
    output logic       ready,
    output logic       overflow,
    output logic       frame_err
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_e;

    logic [2:0]    clk_sync_q;
    logic [1:0]    dat_sync_q;
    logic          fall_c;
    logic          bit_c;

    state_e        state_q, state_d;
    logic [3:0]    count_q, count_d;
    logic [9:0]    shift_q, shift_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          frame_done_c;
    logic          frame_ok_c;
    logic          timeout_c;
    logic          timer_hit_c;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wptr_q, wptr_d;
    logic [AW:0]   rptr_q, rptr_d;
    logic          empty_c, full_c, pop_c, push_c, drop_c;
    logic          ready_q, overflow_q, frame_err_q;

    // Two-flop synchronizers; the third clk stage gives the previous synced value
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_sync_q <= 3'b111;
            dat_sync_q <= 2'b11;
        end else begin
            clk_sync_q <= {clk_sync_q[1:0], ps2_clk};
            dat_sync_q <= {dat_sync_q[0], ps2_data};
        end
    end

    assign fall_c      = clk_sync_q[2] & ~clk_sync_q[1];
    assign bit_c       = dat_sync_q[1];
    assign timer_hit_c = (timer_q == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (fall_c && !bit_c) state_d = RECV;
            RECV: begin
                if (fall_c) begin
                    if (count_q == 4'd10) state_d = IDLE;
                end else if (timer_hit_c) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Frame datapath: start lands in shift_q[9] and drifts to shift_q[0] by the stop bit
    always_comb begin
        count_d      = count_q;
        shift_d      = shift_q;
        timer_d      = timer_q;
        frame_done_c = 1'b0;
        frame_ok_c   = 1'b0;
        timeout_c    = 1'b0;
        unique case (state_q)
            IDLE: begin
                count_d = 4'd0;
                timer_d = '0;
                if (fall_c && !bit_c) begin
                    count_d = 4'd1;
                    shift_d = {bit_c, shift_q[9:1]};
                end
            end
            RECV: begin
                if (fall_c) begin
                    timer_d = '0;
                    if (count_q == 4'd10) begin
                        frame_done_c = 1'b1;
                        frame_ok_c   = ~shift_q[0] & (^shift_q[9:1]) & bit_c;
                        count_d      = 4'd0;
                    end else begin
                        shift_d = {bit_c, shift_q[9:1]};
                        count_d = count_q + 4'd1;
                    end
                end else if (timer_hit_c) begin
                    timeout_c = 1'b1;
                    count_d   = 4'd0;
                    timer_d   = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                count_d = 4'd0;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            count_q     <= 4'd0;
            shift_q     <= 10'h3FF;
            timer_q     <= '0;
            frame_err_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            shift_q     <= shift_d;
            timer_q     <= timer_d;
            frame_err_q <= (frame_done_c & ~frame_ok_c) | timeout_c;
        end
    end

    assign empty_c = (wptr_q == rptr_q);
    assign full_c  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
    assign pop_c   = ~empty_c & ~nextdata_n;
    assign push_c  = frame_ok_c & (~full_c | pop_c);
    assign drop_c  = frame_ok_c & full_c & ~pop_c;
    assign wptr_d  = wptr_q + (AW + 1)'(push_c);
    assign rptr_d  = rptr_q + (AW + 1)'(pop_c);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            ready_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            ready_q    <= (wptr_d != rptr_d);
            overflow_q <= overflow_q | drop_c;
        end
    end

    // Storage needs no reset; only entries between the pointers are ever read
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wptr_q[AW-1:0]] <= shift_q[8:1];
        end
    end

    assign data      = mem[rptr_q[AW-1:0]];
    assign ready     = ready_q;
    assign overflow  = overflow_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed + randomized bench for ps2_keyboard_rx against a queue-based scan-code model.
module tb_ps2_keyboard_rx;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned TMO   = 2000;

    logic       clk = 1'b0;
    logic       clrn;
    logic       ps2_clk;
    logic       ps2_data;
    logic       nextdata_n;
    logic [7:0] data;
    logic       ready;
    logic       overflow;
    logic       frame_err;

    int         checks = 0;
    int         failures = 0;
    int         err_pulses = 0;
    int         err_long = 0;
    logic       err_prev = 1'b0;
    int         exp_err = 0;
    logic [7:0] model_q[$];
    bit         model_ovf = 1'b0;
    time        t_fall;

    always #5 clk = ~clk;

    ps2_keyboard_rx #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .clk        (clk),
        .clrn       (clrn),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .nextdata_n (nextdata_n),
        .data       (data),
        .ready      (ready),
        .overflow   (overflow),
        .frame_err  (frame_err)
    );

    // Count frame_err pulses and any pulse longer than one cycle
    always @(negedge clk) begin
        if (frame_err === 1'b1) begin
            if (err_prev) err_long <= err_long + 1;
            else          err_pulses <= err_pulses + 1;
        end
        err_prev <= frame_err;
    end

    initial begin
        #900us;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
        checks++;
        assert (obs >= lo && obs <= hi) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad_par);
        logic p;
        p = ~(^b) ^ bad_par;
        return {1'b1, p, b, 1'b0};
    endfunction

    // Scan-code model: odd-parity frames queue up to DEPTH, extras set overflow
    task automatic model_frame(input logic [7:0] b, input bit bad, input bit pop);
        if (bad) begin
            exp_err++;
        end else begin
            if (pop && model_q.size() > 0) void'(model_q.pop_front());
            if (model_q.size() < DEPTH) model_q.push_back(b);
            else                        model_ovf = 1'b1;
        end
    endtask

    // mode 0: plain; 1: measure ready latency after last edge; 2: one-cycle pop as frame lands
    task automatic send_raw(input logic [10:0] frm, input int nbits, input int mode);
        int waited;
        @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = frm[i];
            #150;
            ps2_clk = 1'b0;
            t_fall  = $time;
            if (i == nbits - 1 && mode == 1) begin
                waited = 0;
                while (ready !== 1'b1 && waited < 8) begin
                    #10;
                    waited++;
                end
                chk_rng("ready_latency", waited, 2, 4);
                #(300 - 10 * waited);
            end else if (i == nbits - 1 && mode == 2) begin
                #20 nextdata_n = 1'b0;
                #10 nextdata_n = 1'b1;
                #270;
            end else begin
                #300;
            end
            ps2_clk = 1'b1;
            #150;
        end
        ps2_data = 1'b1;
    endtask

    task automatic post_check(input string tag);
        #1;
        chk({tag, "_ready"}, 32'(ready), 32'(model_q.size() != 0));
        if (model_q.size() != 0) chk({tag, "_data"}, 32'(data), 32'(model_q[0]));
        chk({tag, "_ovf"}, 32'(overflow), 32'(model_ovf));
        chk({tag, "_errcnt"}, 32'(err_pulses), 32'(exp_err));
    endtask

    task automatic send_code(input string tag, input logic [7:0] b, input bit bad);
        send_raw(mk_frame(b, bad), 11, 0);
        model_frame(b, bad, 1'b0);
        post_check(tag);
    endtask

    task automatic drain(input string tag);
        @(negedge clk);
        while (model_q.size() > 0) begin
            chk({tag, "_pop_ready"}, 32'(ready), 32'd1);
            chk({tag, "_pop_data"}, 32'(data), 32'(model_q[0]));
            nextdata_n = 1'b0;
            void'(model_q.pop_front());
            @(negedge clk);
        end
        nextdata_n = 1'b1;
        chk({tag, "_empty"}, 32'(ready), 32'd0);
    endtask

    initial begin
        logic [7:0] rb;
        bit         rbad;
        int         waited;

        clrn       = 1'b0;
        ps2_clk    = 1'b1;
        ps2_data   = 1'b1;
        nextdata_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_ferr", 32'(frame_err), 32'd0);
        clrn = 1'b1;
        repeat (3) @(negedge clk);

        // Single code with ready-latency check, then one pop
        send_raw(mk_frame(8'h1C, 1'b0), 11, 1);
        model_frame(8'h1C, 1'b0, 1'b0);
        post_check("t1");
        drain("t1");

        // Three queued codes drained with nextdata_n held low
        send_code("t2a", 8'hF0, 1'b0);
        send_code("t2b", 8'h1C, 1'b0);
        send_code("t2c", 8'h45, 1'b0);
        drain("t2");

        // Bad parity dropped, next good code intact
        send_code("t3bad", 8'h1C, 1'b1);
        send_code("t3good", 8'h32, 1'b0);
        drain("t3");

        // Lone ps2_clk pulse with data high is not a start bit
        send_raw(11'h7FF, 1, 0);
        post_check("glitch");

        // Fill past depth, then push on a full FIFO together with a pop
        for (int i = 1; i <= 9; i++) send_code("t4fill", 8'(i), 1'b0);
        send_raw(mk_frame(8'h0A, 1'b0), 11, 2);
        model_frame(8'h0A, 1'b0, 1'b1);
        post_check("t4simul");
        drain("t4");
        chk("t4_ovf_sticky", 32'(overflow), 32'd1);

        // Partial frame abandoned after the timeout
        send_raw(mk_frame(8'h5A, 1'b0), 5, 0);
        waited = 0;
        while (err_pulses == exp_err && waited < int'(TMO) + 100) begin
            #10;
            waited++;
        end
        exp_err++;
        chk("tmo_pulse", 32'(err_pulses), 32'(exp_err));
        chk_rng("tmo_delay", int'(($time - t_fall) / 10), int'(TMO), int'(TMO) + 5);
        chk("tmo_ready", 32'(ready), 32'd0);
        send_code("tmo_after", 8'h45, 1'b0);
        drain("tmo");

        // Randomized traffic with occasional parity errors and drains
        for (int i = 0; i < 12; i++) begin
            rb   = 8'($urandom);
            rbad = ($urandom_range(0, 3) == 0);
            send_code("rnd", rb, rbad);
            if ($urandom_range(0, 2) == 0) drain("rnd");
        end
        drain("rnd_end");
        for (int i = 0; i < 9; i++) send_code("pre_rst", 8'($urandom), 1'b0);
        drain("pre_rst");

        // Reset mid-frame with two codes queued and overflow set
        send_code("rq1", 8'h11, 1'b0);
        send_code("rq2", 8'h22, 1'b0);
        send_raw(mk_frame(8'h77, 1'b0), 5, 0);
        @(negedge clk);
        clrn = 1'b0;
        #1;
        chk("rst_mid_ready", 32'(ready), 32'd0);
        chk("rst_mid_ovf", 32'(overflow), 32'd0);
        chk("rst_mid_ferr", 32'(frame_err), 32'd0);
        model_q.delete();
        model_ovf = 1'b0;
        repeat (3) @(negedge clk);
        clrn = 1'b1;
        send_code("post_rst", 8'h29, 1'b0);
        drain("post_rst");

        repeat (5) @(negedge clk);
        #1;
        chk("ferr_width", 32'(err_long), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
